// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and instruction constants for the pipeline control blocks
package hazard_pkg;
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2,
      ERROR    = 2'd3
   } state_t;
   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs from the pipeline and stage enable/flush controls back to it
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);
   logic [4:0]       i_id_rs;
   logic [4:0]       i_id_rt;
   logic             i_id_uses_rt;
   logic [4:0]       i_id_ex_rt;
   logic             i_id_ex_memread;
   logic             i_ex_branch_taken;
   logic             i_ex_mem_memaccess;
   logic             i_dmem_ready;
   logic             o_pc_en;
   logic             o_if_id_en;
   logic             o_if_id_flush;
   logic             o_id_ex_en;
   logic             o_id_ex_flush;
   logic             o_ex_mem_en;
   logic             o_mem_wb_bubble;
   logic             o_mem_timeout_err;
   logic [CNT_W-1:0] o_stall_cnt;
   logic [CNT_W-1:0] o_flush_cnt;
   modport master (
      output i_id_rs, i_id_rt, i_id_uses_rt, i_id_ex_rt, i_id_ex_memread,
             i_ex_branch_taken, i_ex_mem_memaccess, i_dmem_ready,
      input  o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush,
             o_ex_mem_en, o_mem_wb_bubble, o_mem_timeout_err, o_stall_cnt, o_flush_cnt
   );
   modport slave (
      input  i_id_rs, i_id_rt, i_id_uses_rt, i_id_ex_rt, i_id_ex_memread,
             i_ex_branch_taken, i_ex_mem_memaccess, i_dmem_ready,
      output o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush,
             o_ex_mem_en, o_mem_wb_bubble, o_mem_timeout_err, o_stall_cnt, o_flush_cnt
   );
endinterface

// File: rtl/lu_detect.sv
// lu_detect: flags an ID instruction reading the destination of a load currently in EX
module lu_detect
   import hazard_pkg::*;
(
   input  logic [4:0] i_id_rs,
   input  logic [4:0] i_id_rt,
   input  logic       i_id_uses_rt,
   input  logic [4:0] i_id_ex_rt,
   input  logic       i_id_ex_memread,
   output logic       o_lu
);
   assign o_lu = i_id_ex_memread && i_id_ex_rt != REG_ZERO &&
                 (i_id_ex_rt == i_id_rs || (i_id_uses_rt && i_id_ex_rt == i_id_rt));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for load-use, taken branch and multi-cycle data memory
module pipe_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int LU_BUBBLES  = 1,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   pipe_hazard_ctrl_if.slave bus
);
   localparam int WAIT_W = $clog2(MEM_TIMEOUT);
   state_t             r_state;
   logic [1:0]         r_lu_left;
   logic [WAIT_W-1:0]  r_wait_cnt;
   logic [CNT_W-1:0]   r_stall_cnt;
   logic [CNT_W-1:0]   r_flush_cnt;
   logic               w_lu;
   logic               w_mem_stall;
   logic               w_freeze;
   logic               w_branch;
   logic               w_lu_stall;
   logic               w_pc_en;

   lu_detect u_lu (
      .i_id_rs         (bus.i_id_rs),
      .i_id_rt         (bus.i_id_rt),
      .i_id_uses_rt    (bus.i_id_uses_rt),
      .i_id_ex_rt      (bus.i_id_ex_rt),
      .i_id_ex_memread (bus.i_id_ex_memread),
      .o_lu            (w_lu)
   );

   assign w_mem_stall = bus.i_ex_mem_memaccess && !bus.i_dmem_ready;
   // a pending memory access outranks everything, including an in-progress load-use stall
   assign w_freeze    = r_state == ERROR || (r_state == MEM_WAIT && !bus.i_dmem_ready) ||
                        ((r_state == RUN || r_state == LU_STALL) && w_mem_stall);
   assign w_branch    = r_state == RUN && !w_mem_stall && bus.i_ex_branch_taken;
   assign w_lu_stall  = !w_freeze && (r_state == LU_STALL || (r_state == RUN && !w_branch && w_lu));
   assign w_pc_en     = rst_n && !w_freeze && !w_lu_stall;

   assign bus.o_pc_en           = w_pc_en;
   assign bus.o_if_id_en        = w_pc_en;
   assign bus.o_id_ex_en        = rst_n && !w_freeze;
   assign bus.o_ex_mem_en       = rst_n && !w_freeze;
   assign bus.o_if_id_flush     = !rst_n || w_branch;
   assign bus.o_id_ex_flush     = !rst_n || w_branch || w_lu_stall;
   assign bus.o_mem_wb_bubble   = !rst_n || w_freeze;
   assign bus.o_mem_timeout_err = r_state == ERROR;
   assign bus.o_stall_cnt       = r_stall_cnt;
   assign bus.o_flush_cnt       = r_flush_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= RUN;
         r_lu_left   <= '0;
         r_wait_cnt  <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (!w_pc_en && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_branch && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
         case (r_state)
            RUN: begin
               if (w_mem_stall) begin
                  r_state    <= MEM_WAIT;
                  r_wait_cnt <= WAIT_W'(1);
               end else if (w_lu_stall && LU_BUBBLES > 1) begin
                  r_state   <= LU_STALL;
                  r_lu_left <= 2'(LU_BUBBLES - 1);
               end
            end
            LU_STALL: begin
               if (w_mem_stall) begin
                  r_state    <= MEM_WAIT;
                  r_wait_cnt <= WAIT_W'(1);
               end else begin
                  r_lu_left <= r_lu_left - 2'd1;
                  if (r_lu_left == 2'd1) r_state <= RUN;
               end
            end
            MEM_WAIT: begin
               if (!bus.i_dmem_ready) begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
                  if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) r_state <= ERROR;
               end else begin
                  r_wait_cnt <= '0;
                  r_state    <= r_lu_left != 2'd0 ? LU_STALL : RUN;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of three parameterisations sharing one stimulus
module tb_pipe_hazard_ctrl;
   // control vector order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, bubble, err
   localparam logic [7:0] C_RUN  = 8'b1101_0100;
   localparam logic [7:0] C_RST  = 8'b0010_1010;
   localparam logic [7:0] C_RSTE = 8'b0010_1011;
   localparam logic [7:0] C_LU   = 8'b0001_1100;
   localparam logic [7:0] C_BR   = 8'b1111_1100;
   localparam logic [7:0] C_FRZ  = 8'b0000_0010;
   localparam logic [7:0] C_ERR  = 8'b0000_0011;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs, id_rt, id_ex_rt;
   logic       id_uses_rt, id_ex_memread, ex_branch_taken, ex_mem_memaccess, dmem_ready;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.CNT_W(32)) if1 ();
   pipe_hazard_ctrl_if #(.CNT_W(2))  if2 ();
   pipe_hazard_ctrl_if #(.CNT_W(32)) if3 ();

   pipe_hazard_ctrl #(.LU_BUBBLES(1), .MEM_TIMEOUT(16), .CNT_W(32)) d1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
   pipe_hazard_ctrl #(.LU_BUBBLES(2), .MEM_TIMEOUT(8),  .CNT_W(2))  d2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
   pipe_hazard_ctrl #(.LU_BUBBLES(3), .MEM_TIMEOUT(8),  .CNT_W(32)) d3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

   assign {if1.i_id_rs, if1.i_id_rt, if1.i_id_uses_rt, if1.i_id_ex_rt, if1.i_id_ex_memread,
           if1.i_ex_branch_taken, if1.i_ex_mem_memaccess, if1.i_dmem_ready} =
          {id_rs, id_rt, id_uses_rt, id_ex_rt, id_ex_memread, ex_branch_taken, ex_mem_memaccess, dmem_ready};
   assign {if2.i_id_rs, if2.i_id_rt, if2.i_id_uses_rt, if2.i_id_ex_rt, if2.i_id_ex_memread,
           if2.i_ex_branch_taken, if2.i_ex_mem_memaccess, if2.i_dmem_ready} =
          {id_rs, id_rt, id_uses_rt, id_ex_rt, id_ex_memread, ex_branch_taken, ex_mem_memaccess, dmem_ready};
   assign {if3.i_id_rs, if3.i_id_rt, if3.i_id_uses_rt, if3.i_id_ex_rt, if3.i_id_ex_memread,
           if3.i_ex_branch_taken, if3.i_ex_mem_memaccess, if3.i_dmem_ready} =
          {id_rs, id_rt, id_uses_rt, id_ex_rt, id_ex_memread, ex_branch_taken, ex_mem_memaccess, dmem_ready};

   wire [7:0] c1 = {if1.o_pc_en, if1.o_if_id_en, if1.o_if_id_flush, if1.o_id_ex_en,
                    if1.o_id_ex_flush, if1.o_ex_mem_en, if1.o_mem_wb_bubble, if1.o_mem_timeout_err};
   wire [7:0] c2 = {if2.o_pc_en, if2.o_if_id_en, if2.o_if_id_flush, if2.o_id_ex_en,
                    if2.o_id_ex_flush, if2.o_ex_mem_en, if2.o_mem_wb_bubble, if2.o_mem_timeout_err};
   wire [7:0] c3 = {if3.o_pc_en, if3.o_if_id_en, if3.o_if_id_flush, if3.o_id_ex_en,
                    if3.o_id_ex_flush, if3.o_ex_mem_en, if3.o_mem_wb_bubble, if3.o_mem_timeout_err};

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      {id_rs, id_rt, id_ex_rt} = '0;
      {id_uses_rt, id_ex_memread, ex_branch_taken, ex_mem_memaccess} = '0;
      dmem_ready = 1'b1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      #1;
      checks++; if (c1 !== C_RST) begin errors++; $display("FAIL reset_forced got %b want %b", c1, C_RST); end
      tick();
      rst_n = 1'b1;
      #1;
      checks++; if (c1 !== C_RUN) begin errors++; $display("FAIL reset_run got %b want %b", c1, C_RUN); end
      checks++; if (if1.o_stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", if1.o_stall_cnt); end
      checks++; if (if1.o_flush_cnt !== 32'd0) begin errors++; $display("FAIL reset_flush_cnt got %0d want 0", if1.o_flush_cnt); end
   endtask

   task automatic test_lu_one();
      do_reset();
      id_ex_memread = 1'b1; id_ex_rt = 5'd5; id_rs = 5'd5;
      #1;
      checks++; if (c1 !== C_LU) begin errors++; $display("FAIL lu1_stall got %b want %b", c1, C_LU); end
      tick();
      idle();
      #1;
      checks++; if (c1 !== C_RUN) begin errors++; $display("FAIL lu1_release got %b want %b", c1, C_RUN); end
      checks++; if (if1.o_stall_cnt !== 32'd1) begin errors++; $display("FAIL lu1_stall_cnt got %0d want 1", if1.o_stall_cnt); end
      id_ex_memread = 1'b1; id_ex_rt = 5'd0; id_rs = 5'd0;
      #1;
      checks++; if (c1 !== C_RUN) begin errors++; $display("FAIL lu1_r0 got %b want %b", c1, C_RUN); end
      tick();
      idle();
      checks++; if (if1.o_stall_cnt !== 32'd1) begin errors++; $display("FAIL lu1_r0_cnt got %0d want 1", if1.o_stall_cnt); end
   endtask

   task automatic test_lu_two();
      do_reset();
      id_ex_memread = 1'b1; id_ex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; id_rs = 5'd3;
      #1;
      checks++; if (c2 !== C_LU) begin errors++; $display("FAIL lu2_first got %b want %b", c2, C_LU); end
      tick();
      idle();
      #1;
      checks++; if (c2 !== C_LU) begin errors++; $display("FAIL lu2_second got %b want %b", c2, C_LU); end
      tick();
      #1;
      checks++; if (c2 !== C_RUN) begin errors++; $display("FAIL lu2_release got %b want %b", c2, C_RUN); end
      checks++; if (if2.o_stall_cnt !== 2'd2) begin errors++; $display("FAIL lu2_stall_cnt got %0d want 2", if2.o_stall_cnt); end
      id_ex_memread = 1'b1; id_ex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b0; id_rs = 5'd3;
      #1;
      checks++; if (c2 !== C_RUN) begin errors++; $display("FAIL lu2_no_rt got %b want %b", c2, C_RUN); end
      tick();
      idle();
      checks++; if (if2.o_stall_cnt !== 2'd2) begin errors++; $display("FAIL lu2_no_rt_cnt got %0d want 2", if2.o_stall_cnt); end
   endtask

   task automatic test_branch();
      do_reset();
      ex_branch_taken = 1'b1;
      #1;
      checks++; if (c1 !== C_BR) begin errors++; $display("FAIL br_flush got %b want %b", c1, C_BR); end
      tick();
      idle();
      #1;
      checks++; if (c1 !== C_RUN) begin errors++; $display("FAIL br_after got %b want %b", c1, C_RUN); end
      checks++; if (if1.o_flush_cnt !== 32'd1) begin errors++; $display("FAIL br_flush_cnt got %0d want 1", if1.o_flush_cnt); end
      ex_branch_taken = 1'b1; id_ex_memread = 1'b1; id_ex_rt = 5'd9; id_rs = 5'd9;
      #1;
      checks++; if (c1 !== C_BR) begin errors++; $display("FAIL br_over_lu got %b want %b", c1, C_BR); end
      tick();
      idle();
      checks++; if (if1.o_flush_cnt !== 32'd2) begin errors++; $display("FAIL br_over_lu_cnt got %0d want 2", if1.o_flush_cnt); end
      checks++; if (if1.o_stall_cnt !== 32'd0) begin errors++; $display("FAIL br_over_lu_stall got %0d want 0", if1.o_stall_cnt); end
   endtask

   task automatic test_saturate();
      do_reset();
      ex_branch_taken = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      idle();
      checks++; if (if2.o_flush_cnt !== 2'd3) begin errors++; $display("FAIL sat_flush_cnt got %0d want 3", if2.o_flush_cnt); end
      checks++; if (if1.o_flush_cnt !== 32'd5) begin errors++; $display("FAIL wide_flush_cnt got %0d want 5", if1.o_flush_cnt); end
   endtask

   task automatic test_mem_wait();
      do_reset();
      ex_mem_memaccess = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
      #1;
      checks++; if (c1 !== C_FRZ) begin errors++; $display("FAIL mem_first got %b want %b", c1, C_FRZ); end
      tick();
      ex_branch_taken = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (c1 !== C_FRZ) begin errors++; $display("FAIL mem_wait%0d got %b want %b", i, c1, C_FRZ); end
         tick();
      end
      dmem_ready = 1'b1;
      #1;
      checks++; if (c1 !== C_RUN) begin errors++; $display("FAIL mem_release got %b want %b", c1, C_RUN); end
      tick();
      idle();
      #1;
      checks++; if (c1 !== C_RUN) begin errors++; $display("FAIL mem_back_run got %b want %b", c1, C_RUN); end
      checks++; if (if1.o_stall_cnt !== 32'd3) begin errors++; $display("FAIL mem_stall_cnt got %0d want 3", if1.o_stall_cnt); end
      checks++; if (if1.o_flush_cnt !== 32'd0) begin errors++; $display("FAIL mem_flush_cnt got %0d want 0", if1.o_flush_cnt); end
   endtask

   task automatic test_timeout();
      do_reset();
      ex_mem_memaccess = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++; if (c2 !== C_FRZ) begin errors++; $display("FAIL to_frozen%0d got %b want %b", i, c2, C_FRZ); end
         tick();
      end
      #1;
      checks++; if (c2 !== C_ERR) begin errors++; $display("FAIL to_error got %b want %b", c2, C_ERR); end
      idle();
      #1;
      checks++; if (c2 !== C_ERR) begin errors++; $display("FAIL to_ready got %b want %b", c2, C_ERR); end
      tick();
      #1;
      checks++; if (c2 !== C_ERR) begin errors++; $display("FAIL to_sticky got %b want %b", c2, C_ERR); end
      rst_n = 1'b0;
      #1;
      checks++; if (c2 !== C_RSTE) begin errors++; $display("FAIL to_in_reset got %b want %b", c2, C_RSTE); end
      tick();
      rst_n = 1'b1;
      #1;
      checks++; if (c2 !== C_RUN) begin errors++; $display("FAIL to_cleared got %b want %b", c2, C_RUN); end
      checks++; if (if2.o_stall_cnt !== 2'd0) begin errors++; $display("FAIL to_cnt_cleared got %0d want 0", if2.o_stall_cnt); end
   endtask

   task automatic test_lu_mem();
      do_reset();
      id_ex_memread = 1'b1; id_ex_rt = 5'd4; id_rs = 5'd4;
      #1;
      checks++; if (c3 !== C_LU) begin errors++; $display("FAIL lm_first got %b want %b", c3, C_LU); end
      tick();
      idle();
      ex_mem_memaccess = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (c3 !== C_FRZ) begin errors++; $display("FAIL lm_freeze%0d got %b want %b", i, c3, C_FRZ); end
         tick();
      end
      dmem_ready = 1'b1;
      #1;
      checks++; if (c3 !== C_RUN) begin errors++; $display("FAIL lm_release got %b want %b", c3, C_RUN); end
      tick();
      idle();
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (c3 !== C_LU) begin errors++; $display("FAIL lm_resume%0d got %b want %b", i, c3, C_LU); end
         tick();
      end
      #1;
      checks++; if (c3 !== C_RUN) begin errors++; $display("FAIL lm_done got %b want %b", c3, C_RUN); end
      checks++; if (if3.o_stall_cnt !== 32'd5) begin errors++; $display("FAIL lm_stall_cnt got %0d want 5", if3.o_stall_cnt); end
   endtask

   initial begin
      test_reset();
      test_lu_one();
      test_lu_two();
      test_branch();
      test_saturate();
      test_mem_wait();
      test_timeout();
      test_lu_mem();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
